adders_tree: RTL and testbench

Two-stage pipelined adder tree. It adds two narrow operands (a+b) and two wide operands (c+d), then adds the two partial sums. All three results are presented as one coherent, registered set. The block sits in the datapath as a small reusable reduction stage: single clock, full-precision (non-truncating) outputs, a valid flag aligned to the results.

---
 rtl/adders_tree.sv | 73 +++++++
 tb/tb_adders_tree.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/adders_tree.sv
// Two-stage pipelined adder tree: registers a+b and c+d, then presents
// both partial sums and their total as one registered, valid-qualified set.
module adders_tree #(
  parameter int unsigned WA = 4,
  parameter int unsigned WC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [WA-1:0] a,
  input  logic [WA-1:0] b,
  input  logic [WC-1:0] c,
  input  logic [WC-1:0] d,
  output logic [WA:0]   sum1,
  output logic [WC:0]   sum2,
  output logic [WC+1:0] sum3,
  output logic          out_valid
);

  localparam int unsigned WS1 = WA + 1;
  localparam int unsigned WS2 = WC + 1;
  localparam int unsigned WS3 = WC + 2;

  if (WC < WA) begin : g_bad_widths
    $error("adders_tree: WC must be >= WA");
  end

  logic [WS1-1:0] p1_q;
  logic [WS2-1:0] p2_q;
  logic           v1_q;
  logic [WS1-1:0] sum1_q;
  logic [WS2-1:0] sum2_q;
  logic [WS3-1:0] sum3_q;
  logic           out_valid_q;

  // Stage 1: partial sums, loaded only for qualified samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q <= '0;
      p2_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        p1_q <= WS1'(a) + WS1'(b);
        p2_q <= WS2'(c) + WS2'(d);
      end
    end
  end

  // Stage 2: all three results captured together so they never mix samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum1_q      <= '0;
      sum2_q      <= '0;
      sum3_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        sum1_q <= p1_q;
        sum2_q <= p2_q;
        sum3_q <= WS3'(p1_q) + WS3'(p2_q);
      end
    end
  end

  assign sum1      = sum1_q;
  assign sum2      = sum2_q;
  assign sum3      = sum3_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adders_tree.sv
// Randomized self-checking bench for adders_tree against a per-cycle
// history model of accepted samples.
module tb_adders_tree;

  localparam int unsigned WA = 4;
  localparam int unsigned WC = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [WA-1:0] a, b;
  logic [WC-1:0] c, d;
  logic [WA:0]   sum1;
  logic [WC:0]   sum2;
  logic [WC+1:0] sum3;
  logic          out_valid;

  adders_tree #(.WA(WA), .WC(WC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .sum1     (sum1),
    .sum2     (sum2),
    .sum3     (sum3),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int a, b, c, d;
  } smp_t;

  smp_t hist[$];
  int   exp_v, exp_s1, exp_s2, exp_s3;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(exp_v));
    check({tag, ".sum1"},  32'(sum1),      32'(exp_s1));
    check({tag, ".sum2"},  32'(sum2),      32'(exp_s2));
    check({tag, ".sum3"},  32'(sum3),      32'(exp_s3));
  endtask

  task automatic model_clear();
    hist.delete();
    exp_v  = 0;
    exp_s1 = 0;
    exp_s2 = 0;
    exp_s3 = 0;
  endtask

  // One clock: drive at negedge, model the edge, check at the next negedge.
  task automatic cycle(input string tag, input bit v, input int ia, input int ib,
                       input int ic, input int id);
    smp_t s;
    smp_t e;
    in_valid = v;
    a = WA'(ia);
    b = WA'(ib);
    c = WC'(ic);
    d = WC'(id);
    @(posedge clk);
    s.v = v; s.a = ia; s.b = ib; s.c = ic; s.d = id;
    hist.push_back(s);
    if (hist.size() > 2) void'(hist.pop_front());
    if (hist.size() == 2) begin
      e = hist[0];
      exp_v = int'(e.v);
      if (e.v) begin
        exp_s1 = e.a + e.b;
        exp_s2 = e.c + e.d;
        exp_s3 = e.a + e.b + e.c + e.d;
      end
    end else begin
      exp_v = 0;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Asynchronous reset asserted mid-cycle; called at a negedge.
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs({tag, ".async"});
    in_valid = 1'b1;
    a = WA'($urandom); b = WA'($urandom); c = WC'($urandom); d = WC'($urandom);
    @(negedge clk);
    check_outputs({tag, ".held"});
    rst_n = 1'b1;
  endtask

  int dir_a[6]  = '{0, 10, 15, 0, 15, 0};
  int dir_b[6]  = '{3, 13, 15, 9, 15, 0};
  int dir_c[6]  = '{1, 9, 109, 45, 255, 0};
  int dir_d[6]  = '{255, 10, 37, 45, 255, 0};
  int dir_s1[6] = '{3, 23, 30, 9, 30, 0};
  int dir_s2[6] = '{256, 19, 146, 90, 510, 0};
  int dir_s3[6] = '{259, 42, 176, 99, 540, 0};

  initial begin
    int ov_count;
    rst_n = 1'b1;
    in_valid = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    model_clear();
    #2 rst_n = 1'b0;
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) cycle("idle", 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

    // Directed rows back to back, then drain; outputs lag by one cycle here.
    for (int i = 0; i < 8; i++) begin
      if (i < 6) cycle("dir", 1'b1, dir_a[i], dir_b[i], dir_c[i], dir_d[i]);
      else       cycle("dir_drain", 1'b0, 0, 0, 0, 0);
      if (i >= 1 && i <= 6) begin
        check("dir_const.valid", 32'(out_valid), 32'd1);
        check("dir_const.sum1",  32'(sum1), 32'(dir_s1[i-1]));
        check("dir_const.sum2",  32'(sum2), 32'(dir_s2[i-1]));
        check("dir_const.sum3",  32'(sum3), 32'(dir_s3[i-1]));
      end
    end

    // Single sample followed by a run of bubbles with junk data.
    ov_count = 0;
    cycle("bubble", 1'b1, 7, 12, 200, 99);
    ov_count += int'(out_valid);
    for (int i = 0; i < 5; i++) begin
      cycle("bubble", 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      ov_count += int'(out_valid);
    end
    check("bubble.pulses", 32'(ov_count), 32'd1);
    check("bubble.hold1", 32'(sum1), 32'd19);
    check("bubble.hold2", 32'(sum2), 32'd299);
    check("bubble.hold3", 32'(sum3), 32'd318);

    mid_reset("async_rst");
    repeat (2) cycle("post_rst", 1'b0, 0, 0, 0, 0);

    // Sample in flight when reset hits must never emerge.
    cycle("flight", 1'b1, 9, 9, 100, 100);
    mid_reset("flight_rst");
    ov_count = 0;
    for (int i = 0; i < 3; i++) begin
      cycle("flight_after", 1'b0, 0, 0, 0, 0);
      ov_count += int'(out_valid);
    end
    check("flight.pulses", 32'(ov_count), 32'd0);
    check("flight.sum3", 32'(sum3), 32'd0);

    for (int i = 0; i < 10000; i++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)));
    end
    repeat (2) cycle("rand_drain", 1'b0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
